// File: rtl/vc_queue_pkg.sv
// Shared definitions for the domain-aware valid/ready queue.
//   state_e             : controller state encoding (RUN / SCRUB)
//   DEFAULT_RESET_VALUE : default contents written on reset and scrub
//   clog2()             : ceiling log2, used for pointer and count widths
package vc_queue_pkg;

  typedef enum logic {
    STATE_RUN   = 1'b0,
    STATE_SCRUB = 1'b1
  } state_e;

  localparam int DEFAULT_RESET_VALUE = 0;

  // Returns the number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/vc_domain_queue_ctrl.sv
// Control path of vc_domain_queue: RUN/SCRUB state machine, head/tail
// pointers, occupancy count, scrub index and valid/ready generation.
// Ports:
//   clk, reset (async, active low), domain      - clock, reset, security domain
//   enq_val / enq_rdy, deq_val / deq_rdy         - handshake signals
//   bypass_sel                                   - deq_msg must come from enq_msg
//   wr_en, wr_scrub, wr_idx                      - storage write port control
//   rd_idx                                       - storage read index (head)
//   count, scrubbing                             - status outputs
module vc_domain_queue_ctrl
  import vc_queue_pkg::*;
#(
  parameter int p_depth  = 4,
  parameter int p_bypass = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         domain,
  input  logic                         enq_val,
  output logic                         enq_rdy,
  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic                         bypass_sel,
  output logic                         wr_en,
  output logic                         wr_scrub,
  output logic [clog2(p_depth)-1:0]    wr_idx,
  output logic [clog2(p_depth)-1:0]    rd_idx,
  output logic [clog2(p_depth+1)-1:0]  count,
  output logic                         scrubbing
);

  // state  | meaning
  // RUN    | normal queue operation for cur_domain
  // SCRUB  | clearing entry[scrub_idx] each cycle; no handshakes

  localparam int PW = clog2(p_depth);
  localparam int CW = clog2(p_depth + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(p_depth - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(p_depth);

  state_e          state_q, state_d;
  logic            cur_domain_q, cur_domain_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   scrub_idx_q, scrub_idx_d;
  logic [CW-1:0]   count_q, count_d;

  logic run_ok, is_full, is_empty;
  logic enq_fire, deq_fire, bypass_fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
  endfunction

  // Gating with reset keeps enq_rdy/deq_val low while reset is held even
  // though the registered state already looks like an idle RUN queue.
  assign run_ok   = reset && (state_q == STATE_RUN) && (domain == cur_domain_q);
  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);

  assign enq_rdy    = run_ok && !is_full;
  assign bypass_sel = (p_bypass != 0) && run_ok && is_empty && enq_val;
  assign deq_val    = run_ok && (!is_empty || bypass_sel);

  assign enq_fire    = enq_val && enq_rdy;
  assign deq_fire    = deq_val && deq_rdy;
  assign bypass_fire = bypass_sel && deq_rdy;
  // A message passed straight through never touches storage.
  assign push        = enq_fire && !bypass_fire;
  assign pop         = deq_fire && !bypass_fire;

  assign scrubbing = (state_q == STATE_SCRUB);
  assign wr_en     = push || scrubbing;
  assign wr_scrub  = scrubbing;
  assign wr_idx    = scrubbing ? scrub_idx_q : tail_q;
  assign rd_idx    = head_q;
  assign count     = count_q;

  always_comb begin
    state_d      = state_q;
    cur_domain_d = cur_domain_q;
    head_d       = head_q;
    tail_d       = tail_q;
    scrub_idx_d  = scrub_idx_q;
    count_d      = count_q;
    if (state_q == STATE_RUN) begin
      if (domain != cur_domain_q) begin
        state_d     = STATE_SCRUB;
        scrub_idx_d = '0;
        head_d      = '0;
        tail_d      = '0;
        count_d     = '0;
      end else begin
        if (push) tail_d = ptr_inc(tail_q);
        if (pop)  head_d = ptr_inc(head_q);
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
      end
    end else begin
      scrub_idx_d = ptr_inc(scrub_idx_q);
      if (scrub_idx_q == LAST_IDX) begin
        state_d      = STATE_RUN;
        cur_domain_d = domain;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= STATE_RUN;
      cur_domain_q <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      scrub_idx_q  <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_domain_q <= cur_domain_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      scrub_idx_q  <= scrub_idx_d;
      count_q      <= count_d;
    end
  end

  a_inputs_known: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({enq_val, deq_rdy, domain}));

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_q <= DEPTH_C);

endmodule

// File: rtl/vc_domain_queue.sv
// Domain-aware p_depth-entry valid/ready queue. On a domain change all
// storage is scrubbed before the new domain may enqueue.
// Ports:
//   clk, reset (async, active low)     - clock and reset
//   domain                             - current security domain
//   enq_val, enq_rdy, enq_msg          - producer side
//   deq_val, deq_rdy, deq_msg          - consumer side (deq_msg idles at p_reset_value)
//   count                              - occupied entries
//   scrubbing                          - high during the scrub phase
module vc_domain_queue
  import vc_queue_pkg::*;
#(
  parameter int                 p_nbits       = 8,
  parameter int                 p_depth       = 4,
  parameter int                 p_bypass      = 0,
  parameter logic [p_nbits-1:0] p_reset_value = p_nbits'(DEFAULT_RESET_VALUE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         domain,
  input  logic                         enq_val,
  output logic                         enq_rdy,
  input  logic [p_nbits-1:0]           enq_msg,
  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic [p_nbits-1:0]           deq_msg,
  output logic [clog2(p_depth+1)-1:0]  count,
  output logic                         scrubbing
);

  localparam int PW = clog2(p_depth);

  logic               bypass_sel, wr_en, wr_scrub;
  logic [PW-1:0]      wr_idx, rd_idx;
  logic [p_nbits-1:0] wr_data, head_msg;
  logic [p_nbits-1:0] entry_q [p_depth];

  vc_domain_queue_ctrl #(
    .p_depth  (p_depth),
    .p_bypass (p_bypass)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .domain     (domain),
    .enq_val    (enq_val),
    .enq_rdy    (enq_rdy),
    .deq_val    (deq_val),
    .deq_rdy    (deq_rdy),
    .bypass_sel (bypass_sel),
    .wr_en      (wr_en),
    .wr_scrub   (wr_scrub),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx),
    .count      (count),
    .scrubbing  (scrubbing)
  );

  assign wr_data = wr_scrub ? p_reset_value : enq_msg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < p_depth; i++) entry_q[i] <= p_reset_value;
    end else if (wr_en) begin
      entry_q[wr_idx] <= wr_data;
    end
  end

  assign head_msg = entry_q[rd_idx];
  assign deq_msg  = !deq_val  ? p_reset_value :
                    bypass_sel ? enq_msg       : head_msg;

endmodule
